// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, default line settings and bit timing.
// The transmitter also uses clks_per_bit, so both ends derive the same bit period.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_BAUD     = 115_200;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs, with a selectable reset value.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of the synchronized line, valid/ready byte output
// with one-cycle frame and overrun error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD     = DEF_BAUD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  if (CLKS_PER_BIT < 4) begin : g_cpb_check
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end

  logic             w_rx_s;
  rx_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_idx, w_idx_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             w_done;
  logic             w_ferr;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_frame_err;
  logic             r_overrun;

  sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
    .i_clk (clk),
    .i_rst (reset),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_done      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rx_s) w_state_nxt = START;
      end
      START: begin
        // A start bit that is gone by mid-bit is treated as a glitch.
        if (r_cnt == CNT_HALF) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = w_rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_cnt == CNT_FULL) begin
          w_cnt_nxt          = '0;
          w_shift_nxt[r_idx] = w_rx_s;
          if (r_idx == 3'd7) w_state_nxt = STOP;
          else               w_idx_nxt   = r_idx + 3'd1;
        end
      end
      STOP: begin
        if (r_cnt == CNT_FULL) begin
          w_cnt_nxt = '0;
          if (w_rx_s) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        // Wait out a held-low line so it cannot be decoded as a stream of 0x00 bytes.
        w_cnt_nxt = '0;
        if (w_rx_s) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      r_overrun   <= 1'b0;
      if (w_done) begin
        if (!r_valid || rx_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data     = r_data;
  assign rx_valid    = r_valid;
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 10 clocks per bit: table-driven frames plus
// hand-written sequences for glitch, break, overrun and mid-frame reset.
module tb_uart_rx;

  localparam int CPB = 10;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;

  uart_rx #(.CLK_FREQ(50_000_000), .BAUD(5_000_000)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int         n_acc  = 0;
  int         n_vcyc = 0;
  int         n_ferr = 0;
  int         n_ovr  = 0;
  logic [7:0] last_acc = 8'h00;

  always @(negedge clk) begin
    if (rx_valid) n_vcyc++;
    if (rx_valid && rx_ready) begin
      n_acc++;
      last_acc = rx_data;
    end
    if (frame_err) n_ferr++;
    if (overrun_err) n_ovr++;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       ready;
    int         gap;
    int         exp_acc;
    logic [7:0] exp_data;
    int         exp_ferr;
    int         exp_ovr;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] mk_frame(input logic [7:0] d, input logic stop);
    return {stop, d, 1'b0};
  endfunction

  // Each bit is held for CPB cycles; callers start and end just after a rising edge.
  task automatic drive_bits(input logic [9:0] f, input int n);
    for (int k = 0; k < n; k++) begin
      rx = f[k];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0, f0, o0, v0;
    logic [9:0] fr;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 20, 1, 8'hA5, 0, 0};
    vecs[1] = '{8'h00, 1'b1, 1'b1,  0, 1, 8'h00, 0, 0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 20, 1, 8'hFF, 0, 0};
    vecs[3] = '{8'h81, 1'b1, 1'b1, 20, 1, 8'h81, 0, 0};
    vecs[4] = '{8'h3C, 1'b0, 1'b1, 20, 0, 8'h00, 1, 0};
    vecs[5] = '{8'h55, 1'b1, 1'b1, 20, 1, 8'h55, 0, 0};

    reset = 1'b1;
    rx = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset rx_valid", rx_valid, 0);
    check("reset rx_data", rx_data, 0);
    check("reset busy", busy, 0);
    check("reset errs", {frame_err, overrun_err}, 0);
    reset = 1'b0;
    idle(5);

    // Exact completion timing of a single 0xA5 frame.
    rx_ready = 1'b1;
    v0 = n_vcyc;
    f0 = n_ferr;
    o0 = n_ovr;
    fr = mk_frame(8'hA5, 1'b1);
    drive_bits(fr, 9);
    rx = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("t1 busy before stop sample", busy, 1);
    check("t1 valid before stop sample", rx_valid, 0);
    @(negedge clk);
    check("t1 busy after stop sample", busy, 0);
    check("t1 valid after stop sample", rx_valid, 1);
    check("t1 rx_data", rx_data, 8'hA5);
    @(negedge clk);
    check("t1 valid one cycle", rx_valid, 0);
    @(posedge clk);
    #1;
    idle(5);
    check("t1 valid cycles", n_vcyc - v0, 1);
    check("t1 frame_err", n_ferr - f0, 0);
    check("t1 overrun_err", n_ovr - o0, 0);

    for (int i = 0; i < 6; i++) begin
      rx_ready = vecs[i].ready;
      a0 = n_acc;
      f0 = n_ferr;
      o0 = n_ovr;
      drive_bits(mk_frame(vecs[i].data, vecs[i].stop), 10);
      idle(vecs[i].gap);
      check($sformatf("vec%0d accepted", i), n_acc - a0, vecs[i].exp_acc);
      if (vecs[i].exp_acc > 0) check($sformatf("vec%0d data", i), last_acc, vecs[i].exp_data);
      check($sformatf("vec%0d frame_err", i), n_ferr - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d overrun_err", i), n_ovr - o0, vecs[i].exp_ovr);
      if (vecs[i].gap > 0) check($sformatf("vec%0d busy idle", i), busy, 0);
    end

    // Short low glitch: START entered, rejected at the mid-bit sample.
    v0 = n_vcyc;
    f0 = n_ferr;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    check("t2 busy in start", busy, 1);
    idle(10);
    check("t2 busy after reject", busy, 0);
    check("t2 no valid", n_vcyc - v0, 0);
    check("t2 no frame_err", n_ferr - f0, 0);

    // Bad stop bit followed by a held-low line.
    rx_ready = 1'b1;
    a0 = n_acc;
    f0 = n_ferr;
    drive_bits(mk_frame(8'h3C, 1'b0), 10);
    rx = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("t3 busy in break", busy, 1);
    check("t3 frame_err once", n_ferr - f0, 1);
    check("t3 no byte", n_acc - a0, 0);
    idle(5);
    check("t3 busy after break", busy, 0);
    drive_bits(mk_frame(8'h81, 1'b1), 10);
    idle(5);
    check("t3 next byte count", n_acc - a0, 1);
    check("t3 next byte data", last_acc, 8'h81);
    check("t3 no extra frame_err", n_ferr - f0, 1);

    // Overrun with the consumer stalled.
    rx_ready = 1'b0;
    o0 = n_ovr;
    drive_bits(mk_frame(8'h11, 1'b1), 10);
    idle(5);
    check("t4 first valid", rx_valid, 1);
    check("t4 first data", rx_data, 8'h11);
    check("t4 no overrun yet", n_ovr - o0, 0);
    drive_bits(mk_frame(8'h22, 1'b1), 10);
    idle(5);
    check("t4 overrun pulse", n_ovr - o0, 1);
    check("t4 data kept", rx_data, 8'h11);
    check("t4 valid kept", rx_valid, 1);
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("t4 valid cleared", rx_valid, 0);
    check("t4 data retained", rx_data, 8'h11);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of bit 4.
    drive_bits(mk_frame(8'h77, 1'b1), 10);
    idle(5);
    check("t5 valid before reset", rx_valid, 1);
    f0 = n_ferr;
    o0 = n_ovr;
    fr = mk_frame(8'h5A, 1'b1);
    drive_bits(fr, 5);
    rx = fr[5];
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("t5 async valid", rx_valid, 0);
    check("t5 async data", rx_data, 0);
    check("t5 async busy", busy, 0);
    check("t5 async errs", {frame_err, overrun_err}, 0);
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(5);
    rx_ready = 1'b1;
    a0 = n_acc;
    drive_bits(mk_frame(8'h5A, 1'b1), 10);
    idle(5);
    check("t5 byte count", n_acc - a0, 1);
    check("t5 byte data", last_acc, 8'h5A);
    check("t5 no frame_err", n_ferr - f0, 0);
    check("t5 no overrun", n_ovr - o0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver that consumes the serial line produced by the top-level transmitter (`uart_tx`).
- Recovers bytes and presents them on a valid/ready byte interface, with framing and overrun flags.
- Serves as the loopback/checker stage downstream of the transmitter.
- Runs from the same 50 MHz system clock.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line bit rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer division, 434 at defaults), clocks per bit period. Elaboration error if < 4.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  serial line; idle high, LSB-first 8N1.
- rx_data  output  8  received byte, held while rx_valid=1.
- rx_valid  output  1  byte available; held until accepted.
- rx_ready  input  1  consumer accepts when rx_valid & rx_ready on a rising edge.
- frame_err  output  1  one-cycle pulse when the stop bit samples 0.
- overrun_err  output  1  one-cycle pulse when a completed byte is dropped.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-high. While reset=1:
  - FSM goes to IDLE.
  - Synchronizer flops and rx_s are set to 1.
  - Bit counter, clock counter and shift register are set to 0.
  - rx_data=0, rx_valid=0, frame_err=0, overrun_err=0, busy=0.
- Reset mid-frame: partial byte discarded, no flag pulses.
- Input sync: rx passes through a 2-flop synchronizer; all decisions use the synchronized value rx_s (2-cycle latency).
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: rx_s=0 -> START, clock counter cleared.
  - START: when counter = CLKS_PER_BIT/2-1, sample rx_s.
    - rx_s=1 -> IDLE (glitch rejected, no flag).
    - rx_s=0 -> DATA, counter and bit index cleared.
  - DATA: when counter = CLKS_PER_BIT-1, sample rx_s into shift bit[index], LSB first, and clear the counter. After index 7 -> STOP.
  - STOP: when counter = CLKS_PER_BIT-1, sample rx_s.
    - rx_s=1 -> byte complete, go to IDLE.
    - rx_s=0 -> frame_err=1 for one cycle, byte discarded, go to BREAK.
  - BREAK: stay until rx_s=1, then IDLE. This keeps a held-low line from producing spurious bytes.
- Sample points are mid-bit. Stop sample lands 9.5 bit periods plus 2 sync cycles after the line's falling edge.
- Output register, updated on the cycle after byte completion:
  - rx_valid=0: load rx_data, set rx_valid=1.
  - rx_valid=1 and rx_ready=1 in the completion cycle: old byte transfers, new byte loads, rx_valid stays 1, no overrun.
  - rx_valid=1 and rx_ready=0: new byte dropped, rx_data unchanged, overrun_err=1 for one cycle.
- Handshake: rx_valid & rx_ready with no completion -> rx_valid=0 next cycle, rx_data retained.
- Back-to-back frames: a start edge detected in IDLE on the cycle right after a stop sample is accepted; no idle gap is required.
- busy = (state != IDLE). busy includes BREAK.

Decomposition:
- Shared package uart_pkg holds:
  - state enum (IDLE, START, DATA, STOP, BREAK);
  - default CLK_FREQ/BAUD constants;
  - a clks_per_bit(clk_freq, baud) function, shared with the transmitter so both ends agree on bit timing.
- One sub-module: sync_2ff, a generic 2-flop synchronizer with a reset-value parameter (1 here). The same cell serves other async inputs.

Test Plan (CLK_FREQ=50000000, BAUD=5000000 -> CLKS_PER_BIT=10):
1. rx_ready=1; drive 0xA5 8N1 (frame bits 0,1,0,1,0,0,1,0,1,1) -> rx_valid high exactly 1 cycle, rx_data=0xA5, frame_err=0, overrun_err=0, busy falls after the stop sample.
2. rx low for 3 cycles, then high -> FSM returns to IDLE at the START sample, no rx_valid, no frame_err.
3. Drive 0x3C with stop bit=0, hold low 30 cycles, then high -> frame_err pulses once, no rx_valid, busy stays 1 until the line is high. A following 0x81 frame is received correctly.
4. rx_ready=0; send 0x11 then 0x22 -> rx_valid latched with 0x11, overrun_err pulses at the 0x22 completion, rx_data stays 0x11. Then raise rx_ready for 1 cycle -> rx_valid=0.
5. Assert reset during bit 4 of 0x5A -> all outputs 0 asynchronously, no flags. After release, a full 0x5A frame -> rx_data=0x5A.
6. Send 0x00 then 0xFF back-to-back (start bit immediately after stop bit), rx_ready=1 -> two rx_valid pulses, data 0x00 then 0xFF, no errors.
